fifo_pkt_sender: RTL and testbench

Read-side companion to the router input FIFO. It drains 8-bit flits from one FIFO and frames them into packets: header byte, length byte, payload. It drives the packets onto a valid/ready link toward the downstream router port. One instance sits on each FIFO output of the NoC node.

---
 rtl/fifo_pkt_sender.sv | 135 +++++++++++++
 tb/tb_fifo_pkt_sender.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_sender.sv
// fifo_pkt_sender
//   Read-side companion to the router input FIFO. Pops 8-bit flits from one
//   FIFO and frames them onto a valid/ready link as packets:
//     byte 0 : header {dst_x[7:4], dst_y[3:0]} (passed through unmodified)
//     byte 1 : payload length N (0..255)
//     bytes 2..N+1 : payload
//
//   Link handshake: a byte is transferred on every rising edge where
//   tx_valid && tx_ready. Once tx_valid is high, tx_data/tx_sop/tx_eop stay
//   stable until that transfer; tx_valid never drops without a transfer
//   (except on reset).
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high
//   en          in   start-of-packet enable, only gates the header pop
//   fifo_out    in   FIFO head data, valid the cycle after fifo_rd
//   fifo_empty  in   FIFO empty flag
//   fifo_rd     out  FIFO pop strobe (combinational from state/en/fifo_empty)
//   tx_data     out  link data
//   tx_valid    out  link data valid
//   tx_ready    in   downstream accept
//   tx_sop      out  tx_data is the header byte
//   tx_eop      out  tx_data is the last byte of the packet
//   busy        out  high from the header pop until the eop handshake
//   pkt_count   out  packets completed on the link, wraps 0xFFFF -> 0
module fifo_pkt_sender #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] fifo_out,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic              busy,
  output logic [15:0]       pkt_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    HDR = 2'd0,
    LEN = 2'd1,
    PAY = 2'd2
  } phase_t;

  state_t            state;
  state_t            next_state;
  phase_t            phase;
  logic [DATA_W-1:0] rem;
  logic              handshake;

  assign handshake = tx_valid && tx_ready;

  // Next-state and pop strobe. A pop is only issued from IDLE, so nothing is
  // popped while a byte is held in SEND. en only matters before a header.
  always_comb begin
    next_state = state;
    fifo_rd    = 1'b0;
    case (state)
      IDLE: begin
        fifo_rd = !fifo_empty && (phase != HDR || en);
        if (fifo_rd) next_state = FETCH;
      end
      FETCH: next_state = SEND;
      SEND: begin
        if (handshake) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= HDR;
      rem       <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      tx_sop    <= 1'b0;
      tx_eop    <= 1'b0;
      busy      <= 1'b0;
      pkt_count <= 16'd0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          // busy is visible from the FETCH cycle of the header onward.
          if (fifo_rd && phase == HDR) busy <= 1'b1;
        end
        FETCH: begin
          tx_data  <= fifo_out;
          tx_valid <= 1'b1;
          tx_sop   <= (phase == HDR);
          // A zero length byte closes the packet; otherwise the last
          // payload byte is the one seen with rem == 1.
          tx_eop   <= (phase == LEN && fifo_out == '0) ||
                      (phase == PAY && rem == DATA_W'(1));
          if (phase == LEN) rem <= fifo_out;
        end
        SEND: begin
          if (handshake) begin
            tx_valid <= 1'b0;
            tx_sop   <= 1'b0;
            tx_eop   <= 1'b0;
            if (phase == PAY) rem <= rem - DATA_W'(1);
            if (tx_eop) begin
              phase     <= HDR;
              busy      <= 1'b0;
              pkt_count <= pkt_count + 16'd1;
            end else begin
              case (phase)
                HDR:     phase <= LEN;
                LEN:     phase <= PAY;
                default: phase <= PAY;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pkt_sender.sv
// Directed bench for fifo_pkt_sender: a behavioural FIFO feeds the DUT, a
// negedge monitor scores every link transfer against an expected queue of
// {sop, eop, data}, and directed sequences cover framing, zero length,
// backpressure, underrun, enable gating, mid-packet reset and counter wrap.
module tb_fifo_pkt_sender;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [7:0]  fifo_out = 8'd0;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sop;
  logic        tx_eop;
  logic        busy;
  logic [15:0] pkt_count;

  // behavioural FIFO
  logic [7:0]  mem [256];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;

  logic [9:0]  exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          rd_pulses = 0;

  fifo_pkt_sender #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .fifo_out   (fifo_out),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_sop     (tx_sop),
    .tx_eop     (tx_eop),
    .busy       (busy),
    .pkt_count  (pkt_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_out <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + 8'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (fifo_rd === 1'b1) begin
      rd_pulses++;
      check("rd_when_empty", fifo_empty, 0);
      check("rd_while_valid", tx_valid, 0);
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
      else check("link_byte", {tx_sop, tx_eop, tx_data}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic expb(input logic s, input logic e, input logic [7:0] d);
    exp_q.push_back({s, e, d});
  endtask

  task automatic wait_valid();
    int i = 0;
    @(negedge clk);
    while (tx_valid !== 1'b1 && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("valid_wait", tx_valid, 1);
  endtask

  task automatic accept_one();
    wait_valid();
    @(posedge clk); #1 tx_ready = 1'b1;
    @(posedge clk); #1 tx_ready = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  int r0;

  initial begin
    reset = 1'b1;
    en = 1'b0;
    tx_ready = 1'b0;
    step(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_sop", tx_sop, 0);
    check("rst_eop", tx_eop, 0);
    check("rst_busy", busy, 0);
    check("rst_count", pkt_count, 0);
    check("rst_rd", fifo_rd, 0);

    // basic packet
    step(1);
    en = 1'b1; tx_ready = 1'b1;
    r0 = rd_pulses;
    expb(1, 0, 8'h23); expb(0, 0, 8'h02); expb(0, 0, 8'hAA); expb(0, 1, 8'hBB);
    push(8'h23); push(8'h02); push(8'hAA); push(8'hBB);
    wait_drain(60);
    check("basic_rd", rd_pulses - r0, 4);
    check("basic_count", pkt_count, 1);
    check("basic_busy", busy, 0);

    // zero-length packet followed by a one-byte packet
    step(1);
    expb(1, 0, 8'h11); expb(0, 1, 8'h00);
    expb(1, 0, 8'h45); expb(0, 0, 8'h01); expb(0, 1, 8'h7E);
    push(8'h11); push(8'h00); push(8'h45); push(8'h01); push(8'h7E);
    wait_drain(80);
    check("zero_count", pkt_count, 3);

    // backpressure on payload byte 0xAA
    step(1);
    tx_ready = 1'b0;
    expb(1, 0, 8'h5A); expb(0, 0, 8'h01); expb(0, 1, 8'hAA);
    push(8'h5A); push(8'h01); push(8'hAA);
    accept_one();
    accept_one();
    wait_valid();
    check("bp_first", tx_data, 8'hAA);
    repeat (5) begin
      @(negedge clk);
      check("bp_data", tx_data, 8'hAA);
      check("bp_valid", tx_valid, 1);
      check("bp_no_rd", fifo_rd, 0);
    end
    accept_one();
    wait_drain(10);
    check("bp_count", pkt_count, 4);

    // underrun after the length byte
    step(1);
    tx_ready = 1'b1;
    r0 = rd_pulses;
    expb(1, 0, 8'h3C); expb(0, 0, 8'h03);
    push(8'h3C); push(8'h03);
    step(12);
    check("ur_rd_stall", rd_pulses - r0, 2);
    check("ur_busy", busy, 1);
    check("ur_sent", exp_q.size(), 0);
    check("ur_count_hold", pkt_count, 4);
    expb(0, 0, 8'h01); expb(0, 0, 8'h02); expb(0, 1, 8'h03);
    push(8'h01); push(8'h02); push(8'h03);
    wait_drain(60);
    check("ur_rd_total", rd_pulses - r0, 5);
    check("ur_count", pkt_count, 5);

    // enable gating, then en dropped mid-packet
    step(1);
    en = 1'b0;
    r0 = rd_pulses;
    push(8'h77); push(8'h01); push(8'h99);
    step(8);
    check("en_block_rd", rd_pulses - r0, 0);
    check("en_block_busy", busy, 0);
    expb(1, 0, 8'h77); expb(0, 0, 8'h01); expb(0, 1, 8'h99);
    en = 1'b1;
    begin
      int i = 0;
      @(negedge clk);
      while (fifo_rd !== 1'b1 && i < 20) begin
        @(negedge clk);
        i++;
      end
      check("en_hdr_pop", fifo_rd, 1);
    end
    @(posedge clk); #1 en = 1'b0;
    wait_drain(60);
    check("en_mid_count", pkt_count, 6);

    // reset while a payload byte is held in SEND
    step(1);
    en = 1'b1; tx_ready = 1'b0;
    expb(1, 0, 8'h42); expb(0, 0, 8'h02);
    push(8'h42); push(8'h02); push(8'hC1); push(8'hC2); push(8'h00);
    accept_one();
    accept_one();
    wait_valid();
    check("rs_held", tx_data, 8'hC1);
    check("rs_busy_pre", busy, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    expb(1, 0, 8'hC2); expb(0, 1, 8'h00);
    @(negedge clk);
    check("rs_valid", tx_valid, 0);
    check("rs_data", tx_data, 0);
    check("rs_sop", tx_sop, 0);
    check("rs_eop", tx_eop, 0);
    check("rs_busy", busy, 0);
    check("rs_count", pkt_count, 0);
    step(1);
    tx_ready = 1'b1;
    wait_drain(40);
    check("rs_count_after", pkt_count, 1);

    // counter wrap
    @(negedge clk);
    force dut.pkt_count = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_count;
    check("wrap_pre", pkt_count, 16'hFFFF);
    step(1);
    expb(1, 0, 8'h01); expb(0, 1, 8'h00);
    push(8'h01); push(8'h00);
    wait_drain(40);
    check("wrap_count", pkt_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
